// File: rtl/rv_ctrl_pipe_if.sv
// Handshake and control-bundle bus for the ID/EX control stage.
// The slave side is the control pipe itself; the master side is whatever
// surrounds it (decode on the upstream side, execute on the downstream side).
interface rv_ctrl_pipe_if;
  // Upstream (decode) handshake and instruction fields
  logic       id_valid_i;
  logic       id_ready_o;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic       flush_i;

  // Downstream (execute) handshake
  logic       ex_valid_o;
  logic       ex_ready_i;

  // Registered control bundle
  logic       branch_o;
  logic       jump_o;
  logic       jalr_o;
  logic       mem_read_o;
  logic       mem_to_reg_o;
  logic       mem_write_o;
  logic       alu2_src_o;
  logic       reg_write_o;
  logic       auipc_o;
  logic       muldiv_o;
  logic       illegal_o;
  logic [1:0] alu1_src_o;
  logic [1:0] reg_read_o;
  logic       busy_o;

  modport master (
    output id_valid_i, opcode_i, funct3_i, funct7_i, flush_i, ex_ready_i,
    input  id_ready_o, ex_valid_o,
    input  branch_o, jump_o, jalr_o, mem_read_o, mem_to_reg_o, mem_write_o,
    input  alu2_src_o, reg_write_o, auipc_o, muldiv_o, illegal_o,
    input  alu1_src_o, reg_read_o, busy_o
  );

  modport slave (
    input  id_valid_i, opcode_i, funct3_i, funct7_i, flush_i, ex_ready_i,
    output id_ready_o, ex_valid_o,
    output branch_o, jump_o, jalr_o, mem_read_o, mem_to_reg_o, mem_write_o,
    output alu2_src_o, reg_write_o, auipc_o, muldiv_o, illegal_o,
    output alu1_src_o, reg_read_o, busy_o
  );
endinterface

// File: rtl/rv_ctrl_pipe.sv
// ID/EX control stage: decodes opcode/funct3/funct7 into the control bundle
// and registers it behind a valid/ready handshake. Optional RV32M detection
// holds the stage busy for a fixed MUL or DIV latency before the bundle is
// offered to EX. flush_i kills anything held or pending.
module rv_ctrl_pipe #(
  parameter bit EN_M       = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter bit EN_FENCE   = 1'b1
) (
  input logic           clk,
  input logic           rstn,
  rv_ctrl_pipe_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  // Counter preload is latency minus one: the accept edge itself is the first cycle.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // A MUL latency longer than the DIV latency cannot be held by the counter.
  generate
    if (MUL_CYCLES < 1 || MUL_CYCLES > DIV_CYCLES) begin : g_bad_latency
      $error("rv_ctrl_pipe: MUL_CYCLES must lie in 1..DIV_CYCLES");
    end
  endgenerate

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu2_src;
    logic       reg_write;
    logic       auipc;
    logic       muldiv;
    logic       illegal;
    logic [1:0] alu1_src;
    logic [1:0] reg_read;
  } ctrl_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             valid_q, valid_nxt;
  ctrl_t            ctrl_q, ctrl_nxt;
  ctrl_t            dec;

  logic             busy;
  logic             id_ready;
  logic             accept;
  logic [CNT_W-1:0] mdiv_load;
  logic             mdiv_single;

  // Only funct3[2] (MUL vs DIV/REM) matters to the control bundle.
  logic             unused_funct3;
  assign unused_funct3 = ^bus.funct3_i[1:0];

  assign busy     = (state_q == ST_WAIT);
  assign id_ready = rstn & ~bus.flush_i & ~busy & (~valid_q | bus.ex_ready_i);
  assign accept   = bus.id_valid_i & id_ready;

  assign mdiv_load   = bus.funct3_i[2] ? DIV_LOAD : MUL_LOAD;
  assign mdiv_single = bus.funct3_i[2] ? (DIV_CYCLES == 1) : (MUL_CYCLES == 1);

  // Instruction decode; anything not recognised becomes an all-zero illegal bundle.
  always_comb begin
    dec = '0;
    case (bus.opcode_i)
      OP_R: begin
        if (bus.funct7_i == 7'b0000000 || bus.funct7_i == 7'b0100000) begin
          dec.reg_read  = 2'b11;
          dec.reg_write = 1'b1;
        end else if (EN_M && bus.funct7_i == 7'b0000001) begin
          dec.reg_read  = 2'b11;
          dec.reg_write = 1'b1;
          dec.muldiv    = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        dec.alu2_src  = 1'b1;
        dec.reg_read  = 2'b01;
        dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu2_src   = 1'b1;
        dec.reg_read   = 2'b01;
        dec.reg_write  = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu2_src  = 1'b1;
        dec.reg_read  = 2'b11;
      end
      OP_BRANCH: begin
        dec.branch   = 1'b1;
        dec.reg_read = 2'b11;
      end
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_JALR: begin
        dec.jump      = 1'b1;
        dec.jalr      = 1'b1;
        dec.alu2_src  = 1'b1;
        dec.reg_read  = 2'b01;
        dec.reg_write = 1'b1;
      end
      OP_LUI: begin
        dec.alu1_src  = 2'b01;
        dec.alu2_src  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec.alu1_src  = 2'b10;
        dec.alu2_src  = 1'b1;
        dec.reg_write = 1'b1;
        dec.auipc     = 1'b1;
      end
      OP_FENCE: begin
        dec.illegal = ~EN_FENCE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Next-state logic: flush wins, otherwise IDLE accepts/drains and WAIT counts down.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    valid_nxt = valid_q;
    ctrl_nxt  = ctrl_q;
    if (bus.flush_i) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      valid_nxt = 1'b0;
      ctrl_nxt  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ctrl_nxt = dec;
            if (dec.muldiv) begin
              cnt_nxt = mdiv_load;
              if (mdiv_single) begin
                valid_nxt = 1'b1;
              end else begin
                valid_nxt = 1'b0;
                state_nxt = ST_WAIT;
              end
            end else begin
              valid_nxt = 1'b1;
            end
          end else if (valid_q && bus.ex_ready_i) begin
            valid_nxt = 1'b0;
          end
        end
        ST_WAIT: begin
          cnt_nxt = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            valid_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and bundle registers; reset drops any pending bundle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      valid_q <= valid_nxt;
      ctrl_q  <= ctrl_nxt;
    end
  end

  assign bus.id_ready_o   = id_ready;
  assign bus.ex_valid_o   = valid_q;
  assign bus.busy_o       = busy;
  assign bus.branch_o     = ctrl_q.branch;
  assign bus.jump_o       = ctrl_q.jump;
  assign bus.jalr_o       = ctrl_q.jalr;
  assign bus.mem_read_o   = ctrl_q.mem_read;
  assign bus.mem_to_reg_o = ctrl_q.mem_to_reg;
  assign bus.mem_write_o  = ctrl_q.mem_write;
  assign bus.alu2_src_o   = ctrl_q.alu2_src;
  assign bus.reg_write_o  = ctrl_q.reg_write;
  assign bus.auipc_o      = ctrl_q.auipc;
  assign bus.muldiv_o     = ctrl_q.muldiv;
  assign bus.illegal_o    = ctrl_q.illegal;
  assign bus.alu1_src_o   = ctrl_q.alu1_src;
  assign bus.reg_read_o   = ctrl_q.reg_read;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// Directed bench for rv_ctrl_pipe. Expected bundles are queued when an
// instruction should be accepted and compared when EX sees them. A second
// instance built without M and FENCE checks the illegal paths.
module tb_rv_ctrl_pipe;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;
  localparam logic [6:0] F7_BAD  = 7'b0000010;

  typedef struct packed {
    logic [1:0] reg_read;
    logic [1:0] alu1_src;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu2_src;
    logic       reg_write;
    logic       auipc;
    logic       muldiv;
    logic       illegal;
  } bundle_t;

  logic clk = 1'b0;
  logic rstn;
  int   tests_run    = 0;
  int   tests_failed = 0;
  bundle_t exp_q[$];

  rv_ctrl_pipe_if bus();
  rv_ctrl_pipe_if bus_nom();

  rv_ctrl_pipe #(
    .EN_M(1'b1), .MUL_CYCLES(2), .DIV_CYCLES(32), .EN_FENCE(1'b1)
  ) u_dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  rv_ctrl_pipe #(
    .EN_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(32), .EN_FENCE(1'b0)
  ) u_dut_nom (
    .clk(clk), .rstn(rstn), .bus(bus_nom)
  );

  always #5 clk = ~clk;

  // Reference decode written straight from the instruction table
  function automatic bundle_t expDecode(input logic [6:0] op, input logic [6:0] f7,
                                        input logic en_m, input logic en_fence);
    bundle_t b;
    b = '0;
    case (op)
      OP_R: begin
        if (f7 == F7_BASE || f7 == F7_ALT) begin
          b.reg_read = 2'b11; b.reg_write = 1'b1;
        end else if (f7 == F7_M && en_m) begin
          b.reg_read = 2'b11; b.reg_write = 1'b1; b.muldiv = 1'b1;
        end else begin
          b.illegal = 1'b1;
        end
      end
      OP_I:      begin b.alu2_src = 1'b1; b.reg_read = 2'b01; b.reg_write = 1'b1; end
      OP_LOAD:   begin b.mem_read = 1'b1; b.mem_to_reg = 1'b1; b.alu2_src = 1'b1;
                       b.reg_read = 2'b01; b.reg_write = 1'b1; end
      OP_STORE:  begin b.mem_write = 1'b1; b.alu2_src = 1'b1; b.reg_read = 2'b11; end
      OP_BRANCH: begin b.branch = 1'b1; b.reg_read = 2'b11; end
      7'b1101111: begin b.jump = 1'b1; b.reg_write = 1'b1; end
      OP_JALR:   begin b.jump = 1'b1; b.jalr = 1'b1; b.alu2_src = 1'b1;
                       b.reg_read = 2'b01; b.reg_write = 1'b1; end
      OP_LUI:    begin b.alu1_src = 2'b01; b.alu2_src = 1'b1; b.reg_write = 1'b1; end
      OP_AUIPC:  begin b.alu1_src = 2'b10; b.alu2_src = 1'b1; b.reg_write = 1'b1;
                       b.auipc = 1'b1; end
      OP_FENCE:  b.illegal = !en_fence;
      default:   b.illegal = 1'b1;
    endcase
    return b;
  endfunction

  function automatic bundle_t mainBundle();
    bundle_t b;
    b.reg_read   = bus.reg_read_o;
    b.alu1_src   = bus.alu1_src_o;
    b.branch     = bus.branch_o;
    b.jump       = bus.jump_o;
    b.jalr       = bus.jalr_o;
    b.mem_read   = bus.mem_read_o;
    b.mem_to_reg = bus.mem_to_reg_o;
    b.mem_write  = bus.mem_write_o;
    b.alu2_src   = bus.alu2_src_o;
    b.reg_write  = bus.reg_write_o;
    b.auipc      = bus.auipc_o;
    b.muldiv     = bus.muldiv_o;
    b.illegal    = bus.illegal_o;
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic fl, input logic er);
    bus.id_valid_i     = v;  bus_nom.id_valid_i = v;
    bus.opcode_i       = op; bus_nom.opcode_i   = op;
    bus.funct3_i       = f3; bus_nom.funct3_i   = f3;
    bus.funct7_i       = f7; bus_nom.funct7_i   = f7;
    bus.flush_i        = fl; bus_nom.flush_i    = fl;
    bus.ex_ready_i     = er; bus_nom.ex_ready_i = er;
  endtask

  // Whenever EX sees a bundle it must match the oldest queued expectation
  task automatic monitor(input string tag);
    if (bus.ex_valid_o) begin
      checkOutput({tag, "_sb_pending"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        checkOutput({tag, "_bundle"}, 32'(mainBundle()), 32'(exp_q[0]));
        if (bus.ex_ready_i) void'(exp_q.pop_front());
      end
    end
  endtask

  // One cycle: drive inputs, check {id_ready, ex_valid, busy} mid-cycle, then clock
  task automatic applyStimulus(input string tag, input logic v, input logic [6:0] op,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic fl, input logic er, input logic [2:0] exp_rvb);
    drive(v, op, f3, f7, fl, er);
    @(negedge clk);
    checkOutput({tag, "_id_ready"}, 32'(bus.id_ready_o), 32'(exp_rvb[2]));
    checkOutput({tag, "_ex_valid"}, 32'(bus.ex_valid_o), 32'(exp_rvb[1]));
    checkOutput({tag, "_busy"},     32'(bus.busy_o),     32'(exp_rvb[0]));
    monitor(tag);
    if (fl) exp_q.delete();
    if (v && exp_rvb[2]) exp_q.push_back(expDecode(op, f7, 1'b1, 1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [2:0] exp_rvb);
    applyStimulus(tag, 1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b1, exp_rvb);
  endtask

  initial begin
    // Reset state, with an instruction offered while reset is held
    rstn = 1'b0;
    drive(1'b1, OP_I, 3'd0, F7_BASE, 1'b0, 1'b1);
    #2;
    checkOutput("rst_id_ready", 32'(bus.id_ready_o), 32'd0);
    checkOutput("rst_ex_valid", 32'(bus.ex_valid_o), 32'd0);
    checkOutput("rst_busy",     32'(bus.busy_o),     32'd0);
    checkOutput("rst_bundle",   32'(mainBundle()),   32'd0);
    @(posedge clk);
    drive(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b1);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    idle("post_rst", 3'b100);

    // Pipelined decode stream, one bundle per cycle
    applyStimulus("p_r",     1'b1, OP_R,     3'd0, F7_BASE, 1'b0, 1'b1, 3'b100);
    applyStimulus("p_load",  1'b1, OP_LOAD,  3'd2, F7_BASE, 1'b0, 1'b1, 3'b110);
    applyStimulus("p_store", 1'b1, OP_STORE, 3'd2, F7_BASE, 1'b0, 1'b1, 3'b110);
    applyStimulus("p_jalr",  1'b1, OP_JALR,  3'd0, F7_BASE, 1'b0, 1'b1, 3'b110);
    applyStimulus("p_lui",   1'b1, OP_LUI,   3'd0, F7_BASE, 1'b0, 1'b1, 3'b110);
    applyStimulus("p_auipc", 1'b1, OP_AUIPC, 3'd0, F7_BASE, 1'b0, 1'b1, 3'b110);
    idle("p_tail", 3'b110);
    idle("p_empty", 3'b100);

    // Backpressure: I-type held for three cycles, branch waits then enters
    applyStimulus("bp_i",    1'b1, OP_I,      3'd0, F7_BASE, 1'b0, 1'b1, 3'b100);
    for (int k = 0; k < 3; k++)
      applyStimulus("bp_hold", 1'b1, OP_BRANCH, 3'd0, F7_BASE, 1'b0, 1'b0, 3'b010);
    applyStimulus("bp_rel",  1'b1, OP_BRANCH, 3'd0, F7_BASE, 1'b0, 1'b1, 3'b110);
    idle("bp_tail", 3'b110);
    idle("bp_empty", 3'b100);

    // FENCE and illegal encodings
    applyStimulus("fence",   1'b1, OP_FENCE, 3'd0, F7_BASE, 1'b0, 1'b1, 3'b100);
    checkOutput("nom_fence_valid",   32'(bus_nom.ex_valid_o), 32'd1);
    checkOutput("nom_fence_illegal", 32'(bus_nom.illegal_o),  32'd1);
    applyStimulus("ill_op",  1'b1, OP_BAD,   3'd7, 7'h7f,   1'b0, 1'b1, 3'b110);
    applyStimulus("ill_f7",  1'b1, OP_R,     3'd0, F7_BAD,  1'b0, 1'b1, 3'b110);
    applyStimulus("r_sub",   1'b1, OP_R,     3'd0, F7_ALT,  1'b0, 1'b1, 3'b110);
    idle("ill_tail", 3'b110);
    idle("ill_empty", 3'b100);

    // MUL: two-cycle latency, bundle visible while waiting
    applyStimulus("mul_acc", 1'b1, OP_R, 3'b000, F7_M, 1'b0, 1'b1, 3'b100);
    checkOutput("mul_wait_bundle", 32'(mainBundle()),
                32'(expDecode(OP_R, F7_M, 1'b1, 1'b1)));
    checkOutput("nom_mul_valid",   32'(bus_nom.ex_valid_o), 32'd1);
    checkOutput("nom_mul_illegal", 32'(bus_nom.illegal_o),  32'd1);
    checkOutput("nom_mul_muldiv",  32'(bus_nom.muldiv_o),   32'd0);
    idle("mul_wait", 3'b001);
    idle("mul_done", 3'b110);
    idle("mul_empty", 3'b100);

    // DIV: busy for 31 edges, bundle presented after the 31st
    applyStimulus("div_acc", 1'b1, OP_R, 3'b100, F7_M, 1'b0, 1'b1, 3'b100);
    checkOutput("nom_div_illegal", 32'(bus_nom.illegal_o), 32'd1);
    for (int k = 0; k < 31; k++) idle("div_wait", 3'b001);
    idle("div_done", 3'b110);
    idle("div_empty", 3'b100);

    // Flush while REM waits with counter at 10; offered instruction is refused
    applyStimulus("fl_acc", 1'b1, OP_R, 3'b110, F7_M, 1'b0, 1'b1, 3'b100);
    for (int k = 0; k < 21; k++) idle("fl_wait", 3'b001);
    applyStimulus("fl_cyc", 1'b1, OP_I, 3'd0, F7_BASE, 1'b1, 1'b1, 3'b001);
    checkOutput("fl_bundle_zero", 32'(mainBundle()), 32'd0);
    idle("fl_after", 3'b100);
    applyStimulus("fl_next", 1'b1, OP_I, 3'd0, F7_BASE, 1'b0, 1'b1, 3'b100);
    idle("fl_next_out", 3'b110);
    idle("fl_empty", 3'b100);

    // Asynchronous reset in the middle of a DIV wait
    applyStimulus("rw_acc", 1'b1, OP_R, 3'b101, F7_M, 1'b0, 1'b1, 3'b100);
    for (int k = 0; k < 3; k++) idle("rw_wait", 3'b001);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rw_id_ready", 32'(bus.id_ready_o), 32'd0);
    checkOutput("rw_ex_valid", 32'(bus.ex_valid_o), 32'd0);
    checkOutput("rw_busy",     32'(bus.busy_o),     32'd0);
    checkOutput("rw_bundle",   32'(mainBundle()),   32'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    idle("rw_after", 3'b100);

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
